// File: rtl/clock_ratio_detector_if.sv
// rtl/clock_ratio_detector_if.sv - clk_in sample input and period/ratio/lock result bundle
interface clock_ratio_detector_if #(
  parameter int CNT_W = 8
);
  logic             clk_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic [CNT_W-1:0] ratio;
  logic             locked;
  logic             err;

  // detector side: samples clk_in, drives the measurement results
  modport master (
    input  clk_in,
    output period_out, period_valid, ratio, locked, err
  );

  // stimulus/consumer side
  modport slave (
    output clk_in,
    input  period_out, period_valid, ratio, locked, err
  );
endinterface

// File: rtl/clock_ratio_detector.sv
// rtl/clock_ratio_detector.sv - measures clk_in period in clk cycles and locks onto a stable ratio
module clock_ratio_detector #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_ratio_detector_if.master bus
);
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_TRACK,
    ST_LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);
  localparam logic [4:0]       LOCK_N  = 5'(LOCK_COUNT);

  state_t           state_q, state_d;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [3:0]       match_q, match_d;
  logic             pv_q, pv_d;
  logic             err_q, err_d;
  logic [CNT_W:0]   diff;
  logic             in_tol;
  logic             lock_hit;
  logic             at_max;

  // two-flop synchronizer plus a history flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign at_max   = (cnt_q == CNT_MAX);
  // unsigned distance at CNT_W+1 bits so the subtraction can never wrap
  assign diff     = (cnt_q >= ref_q) ? ({1'b0, cnt_q} - {1'b0, ref_q})
                                     : ({1'b0, ref_q} - {1'b0, cnt_q});
  assign in_tol   = (diff <= TOL_V);
  assign lock_hit = (({1'b0, match_q} + 5'd1) == LOCK_N);

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ref_q    <= '0;
      period_q <= '0;
      ratio_q  <= '0;
      match_q  <= '0;
      pv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      period_q <= period_d;
      ratio_q  <= ratio_d;
      match_q  <= match_d;
      pv_q     <= pv_d;
      err_q    <= err_d;
    end
  end

  // next-state and next-value logic; a rise always beats the timeout
  always_comb begin
    state_d  = state_q;
    cnt_d    = rise ? CNT_W'(1) : (at_max ? cnt_q : cnt_q + CNT_W'(1));
    ref_d    = ref_q;
    period_d = period_q;
    ratio_d  = ratio_q;
    match_d  = match_q;
    pv_d     = 1'b0;
    err_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = rise ? CNT_W'(1) : '0;
      if (rise) state_d = ST_MEASURE;
    end else if (rise) begin
      pv_d     = 1'b1;
      period_d = cnt_q;
      case (state_q)
        ST_MEASURE: begin
          ref_d   = cnt_q;
          match_d = '0;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (in_tol) begin
            match_d = match_q + 4'd1;
            if (lock_hit) begin
              state_d = ST_LOCKED;
              ratio_d = ref_q;
            end
          end else begin
            ref_d   = cnt_q;
            match_d = '0;
          end
        end
        default: begin
          if (!in_tol) begin
            err_d   = 1'b1;
            state_d = ST_TRACK;
            ref_d   = cnt_q;
            match_d = '0;
            ratio_d = '0;
          end
        end
      endcase
    end else if (at_max) begin
      err_d   = (state_q == ST_TRACK) || (state_q == ST_LOCKED);
      state_d = ST_IDLE;
      cnt_d   = '0;
      ref_d   = '0;
      match_d = '0;
      ratio_d = '0;
    end
  end

  assign bus.period_out   = period_q;
  assign bus.period_valid = pv_q;
  assign bus.ratio        = ratio_q;
  assign bus.locked       = (state_q == ST_LOCKED);
  assign bus.err          = err_q;
endmodule

// File: tb/tb_clock_ratio_detector.sv
// tb/tb_clock_ratio_detector.sv - directed self-checking bench for clock_ratio_detector
module tb_clock_ratio_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_in_drv = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // stats collected at each negedge sample
  int cyc_n = 0;
  int pv_n, err_n, last_per, lock_at, err_at_pv, err_locked_n, per_bad, exp_per;
  int last_pv_cyc = 0;
  int err_cyc, tol0_lock_n;
  logic locked_prev = 1'b0;

  clock_ratio_detector_if #(.CNT_W(8)) bus0 ();
  clock_ratio_detector_if #(.CNT_W(8)) bus1 ();

  assign bus0.clk_in = clk_in_drv;
  assign bus1.clk_in = clk_in_drv;

  clock_ratio_detector #(.CNT_W(8), .LOCK_COUNT(4), .TOL(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.master)
  );

  clock_ratio_detector #(.CNT_W(8), .LOCK_COUNT(4), .TOL(1)) u_tol (
    .clk (clk),
    .rst (rst),
    .bus (bus1.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    pv_n = 0; err_n = 0; last_per = 0; lock_at = 0; err_at_pv = 0;
    err_locked_n = 0; per_bad = 0; exp_per = 0; err_cyc = 0; tol0_lock_n = 0;
  endtask

  // one clk cycle: sample outputs at the negedge, then drive the next clk_in level
  task automatic cyc(input logic v);
    @(negedge clk);
    cyc_n++;
    if (bus0.period_valid) begin
      pv_n++;
      last_per = 32'(bus0.period_out);
      last_pv_cyc = cyc_n;
      if (exp_per != 0 && 32'(bus0.period_out) != exp_per) per_bad++;
    end
    if (bus0.err) begin
      err_n++;
      err_at_pv = pv_n;
      err_cyc = cyc_n;
      if (bus0.locked) err_locked_n++;
    end
    if (bus0.locked && !locked_prev && lock_at == 0) lock_at = pv_n;
    if (bus0.locked) tol0_lock_n++;
    locked_prev = bus0.locked;
    clk_in_drv = v;
  endtask

  task automatic clk_wave(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) cyc(1'b1);
      for (int i = 0; i < lo; i++) cyc(1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    clear_stats();
    // reset state
    do_reset();
    chk("rst_period_out", 32'(bus0.period_out), 0);
    chk("rst_period_valid", 32'(bus0.period_valid), 0);
    chk("rst_ratio", 32'(bus0.ratio), 0);
    chk("rst_locked", 32'(bus0.locked), 0);
    chk("rst_err", 32'(bus0.err), 0);

    // steady clk/4: 8 rises -> 7 captures of 4, lock on the 5th
    clear_stats();
    exp_per = 4;
    clk_wave(2, 2, 8);
    chk("div4_pv_count", pv_n, 7);
    chk("div4_period_bad", per_bad, 0);
    chk("div4_lock_at", lock_at, 5);
    chk("div4_ratio", 32'(bus0.ratio), 4);
    chk("div4_locked", 32'(bus0.locked), 1);
    chk("div4_err", err_n, 0);

    // switch to clk/6: one bridging 4, then err on the first 6, relock 4 captures later
    clear_stats();
    clk_wave(3, 3, 8);
    chk("div6_pv_count", pv_n, 8);
    chk("div6_err_count", err_n, 1);
    chk("div6_err_at_pv", err_at_pv, 2);
    chk("div6_locked_at_err", err_locked_n, 0);
    chk("div6_lock_at", lock_at, 6);
    chk("div6_ratio", 32'(bus0.ratio), 6);
    chk("div6_last_period", last_per, 6);

    // hold clk_in low from LOCKED: timeout 255 cycles after the last cnt<=1
    clear_stats();
    for (int i = 0; i < 300; i++) cyc(1'b0);
    chk("tmo_err_count", err_n, 1);
    chk("tmo_delay", err_cyc - last_pv_cyc, 255);
    chk("tmo_pv_count", pv_n, 0);
    chk("tmo_ratio", 32'(bus0.ratio), 0);
    chk("tmo_locked", 32'(bus0.locked), 0);

    // reset while locked, then relock from IDLE
    do_reset();
    clear_stats();
    clk_wave(2, 2, 7);
    chk("mid_locked_before", 32'(bus0.locked), 1);
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
    chk("mid_period_out", 32'(bus0.period_out), 0);
    chk("mid_period_valid", 32'(bus0.period_valid), 0);
    chk("mid_ratio", 32'(bus0.ratio), 0);
    chk("mid_locked", 32'(bus0.locked), 0);
    chk("mid_err", err_n, 0);
    clear_stats();
    clk_wave(2, 2, 7);
    chk("mid_relock_pv", pv_n, 6);
    chk("mid_relock_at", lock_at, 5);
    chk("mid_relock_ratio", 32'(bus0.ratio), 4);

    // periods alternating 4,5: TOL=1 locks at the first ref, TOL=0 never locks
    do_reset();
    clear_stats();
    for (int k = 0; k < 8; k++) begin
      clk_wave(2, 2, 1);
      clk_wave(2, 3, 1);
    end
    chk("tol1_locked", 32'(bus1.locked), 1);
    chk("tol1_ratio", 32'(bus1.ratio), 4);
    chk("tol0_lock_cycles", tol0_lock_n, 0);

    // period 255 captured without timeout; 256 times out from TRACK
    do_reset();
    clear_stats();
    clk_wave(1, 254, 2);
    chk("p255_pv_count", pv_n, 1);
    chk("p255_period", last_per, 255);
    chk("p255_err", err_n, 0);
    for (int i = 0; i < 10; i++) cyc(1'b0);
    chk("p256_err", err_n, 1);
    chk("p256_pv_count", pv_n, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
